// File: rtl/data_mem_responder_if.sv
// Request/response bundle between the core control path
// and the data-memory responder.
interface data_mem_responder_if;
  logic        read_enable;
  logic [3:0]  mem_write_en;
  logic [2:0]  load_funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        halt;
  logic        mem_stall;
  logic [31:0] rdata;
  logic        rvalid;
  logic        wack;
  logic        mem_err;

  modport master (
    output read_enable, mem_write_en, load_funct3,
    output addr, wdata, halt,
    input  mem_stall, rdata, rvalid, wack, mem_err
  );

  modport slave (
    input  read_enable, mem_write_en, load_funct3,
    input  addr, wdata, halt,
    output mem_stall, rdata, rvalid, wack, mem_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Word-organised data RAM answering RV32I loads/stores after
// a fixed latency, with stall, alignment and range checking.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input logic                 clk,
  input logic                 rst,
  data_mem_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  strb_q;
  logic [2:0]  f3_q;
  logic        rd_q, err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] mem [DEPTH_WORDS];

  logic        req, accept, access, use_live;
  logic [31:0] a_addr, a_wdata, word_v, ext_v;
  logic [3:0]  a_strb;
  logic [2:0]  a_f3;
  logic        a_rd, oor, lerr, serr, err, wr_en;
  logic [AW-1:0] widx;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign req    = bus.read_enable | (|bus.mem_write_en);
  assign accept = (state_q == IDLE) & req & ~bus.halt;

  // The accept cycle counts as the first stall cycle, so the
  // access fires on the edge that closes stall cycle LATENCY.
  assign access = ((state_q == WAIT) & (cnt_q == 4'd1))
                | ((LATENCY == 1) & accept);

  // Only a LATENCY==1 access happens while still in IDLE.
  assign use_live = (state_q == IDLE);
  assign a_addr   = use_live ? bus.addr         : addr_q;
  assign a_wdata  = use_live ? bus.wdata        : wdata_q;
  assign a_strb   = use_live ? bus.mem_write_en : strb_q;
  assign a_f3     = use_live ? bus.load_funct3  : f3_q;
  assign a_rd     = use_live ? bus.read_enable  : rd_q;

  assign widx   = a_addr[AW+1:2];
  assign oor    = |a_addr[31:AW+2];
  assign word_v = mem[widx];
  assign byte_v = word_v[{a_addr[1:0], 3'b000} +: 8];
  assign half_v = a_addr[1] ? word_v[31:16] : word_v[15:0];

  always_comb begin
    lerr  = 1'b0;
    ext_v = word_v;
    unique case (a_f3)
      3'b000: ext_v = {{24{byte_v[7]}}, byte_v};
      3'b100: ext_v = {24'd0, byte_v};
      3'b001: begin
        ext_v = {{16{half_v[15]}}, half_v};
        lerr  = a_addr[0];
      end
      3'b101: begin
        ext_v = {16'd0, half_v};
        lerr  = a_addr[0];
      end
      3'b010: lerr = |a_addr[1:0];
      default: lerr = 1'b1;
    endcase
  end

  assign serr = ~(a_strb inside {4'b0001, 4'b0010, 4'b0100,
                                 4'b1000, 4'b0011, 4'b1100,
                                 4'b1111})
              | ~a_strb[a_addr[1:0]];
  assign err   = oor | (a_rd ? ((|a_strb) | lerr) : serr);
  assign wr_en = access & ~a_rd & ~err & ~rst;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: if (accept) begin
        cnt_d   = 4'(LATENCY - 1);
        state_d = (LATENCY == 1) ? RESP : WAIT;
      end
      WAIT: begin
        if (cnt_q == 4'd1) state_d = RESP;
        else cnt_d = cnt_q - 4'd1;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (access) begin
      err_d = err;
      if (a_rd) rdata_d = err ? 32'd0 : ext_v;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      f3_q    <= '0;
      rd_q    <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      if (accept) begin
        addr_q  <= bus.addr;
        wdata_q <= bus.wdata;
        strb_q  <= bus.mem_write_en;
        f3_q    <= bus.load_funct3;
        rd_q    <= bus.read_enable;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++)
        if (a_strb[i]) mem[widx][8*i +: 8] <= a_wdata[8*i +: 8];
    end
  end

  assign bus.mem_stall = ~rst & (accept | (state_q == WAIT));
  assign bus.rvalid    = (state_q == RESP) & rd_q;
  assign bus.wack      = (state_q == RESP) & ~rd_q;
  assign bus.mem_err   = (state_q == RESP) & err_q;
  assign bus.rdata     = rdata_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Randomised self-checking bench for data_mem_responder
// at LATENCY 2, plus stall-length checks at 1 and 15.
module tb_data_mem_responder;
  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        re, halt;
  logic [3:0]  we;
  logic [2:0]  f3;
  logic [31:0] ad, wd;
  int          sel;

  data_mem_responder_if b0 ();
  data_mem_responder_if b1 ();
  data_mem_responder_if b2 ();

  assign b0.read_enable  = re & (sel == 0);
  assign b1.read_enable  = re & (sel == 1);
  assign b2.read_enable  = re & (sel == 2);
  assign b0.mem_write_en = (sel == 0) ? we : 4'd0;
  assign b1.mem_write_en = (sel == 1) ? we : 4'd0;
  assign b2.mem_write_en = (sel == 2) ? we : 4'd0;
  assign b0.load_funct3 = f3;
  assign b1.load_funct3 = f3;
  assign b2.load_funct3 = f3;
  assign b0.addr  = ad;
  assign b1.addr  = ad;
  assign b2.addr  = ad;
  assign b0.wdata = wd;
  assign b1.wdata = wd;
  assign b2.wdata = wd;
  assign b0.halt  = halt;
  assign b1.halt  = halt;
  assign b2.halt  = halt;

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2))
    u0 (.clk(clk), .rst(rst), .bus(b0));
  data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1))
    u1 (.clk(clk), .rst(rst), .bus(b1));
  data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(15))
    u2 (.clk(clk), .rst(rst), .bus(b2));

  logic        o_st, o_rv, o_wk, o_er;
  logic [31:0] o_rd;

  always_comb begin
    o_st = b0.mem_stall;
    o_rv = b0.rvalid;
    o_wk = b0.wack;
    o_er = b0.mem_err;
    o_rd = b0.rdata;
    if (sel == 1) begin
      o_st = b1.mem_stall;
      o_rv = b1.rvalid;
      o_wk = b1.wack;
      o_er = b1.mem_err;
      o_rd = b1.rdata;
    end else if (sel == 2) begin
      o_st = b2.mem_stall;
      o_rv = b2.rvalid;
      o_wk = b2.wack;
      o_er = b2.mem_err;
      o_rd = b2.rdata;
    end
  end

  int vec = 0;
  int bad = 0;
  logic [31:0] last;
  logic [31:0] ref_mem [DEPTH];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    vec++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Reference: byte-addressed view of the RAM with RV32I rules.
  task automatic model(input bit r, input logic [3:0] s,
                       input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] w,
                       output bit err, output logic [31:0] d);
    int sz, off;
    bit oor;
    longint v;
    logic [31:0] wrd;
    oor = (a >> 2) >= DEPTH;
    off = int'(a % 4);
    d   = 32'd0;
    err = 1'b0;
    if (r) begin
      case (f)
        3'd0, 3'd4: sz = 1;
        3'd1, 3'd5: sz = 2;
        3'd2:       sz = 4;
        default:    sz = 0;
      endcase
      if (s != 0 || sz == 0 || oor) err = 1'b1;
      else if (off % sz != 0) err = 1'b1;
      if (!err) begin
        v = longint'(ref_mem[a >> 2]) >> (8 * off);
        v = v & ((64'd1 << (8 * sz)) - 1);
        if (f < 3'd4 && v >= (64'd1 << (8 * sz - 1)))
          v = v - (64'd1 << (8 * sz));
        d = v[31:0];
      end
    end else begin
      err = !(s inside {4'd1, 4'd2, 4'd4, 4'd8, 4'd3, 4'd12, 4'd15})
            || !s[off] || oor;
      if (!err) begin
        wrd = ref_mem[a >> 2];
        for (int b = 0; b < 4; b++)
          if (s[b]) wrd[8*b +: 8] = w[8*b +: 8];
        ref_mem[a >> 2] = wrd;
      end
    end
  endtask

  task automatic xact(input bit r, input logic [3:0] s,
                      input logic [2:0] f, input logic [31:0] a,
                      input logic [31:0] w, input bit hmid,
                      output int stalls, output bit gr, output bit gw,
                      output bit ge, output logic [31:0] gd);
    bit done;
    done = 1'b0;
    @(posedge clk);
    #1;
    re = r; we = s; f3 = f; ad = a; wd = w;
    stalls = 0; gr = 0; gw = 0; ge = 0; gd = '0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (o_st) stalls++;
      if (o_rv | o_wk) begin
        done = 1'b1;
        gr = o_rv; gw = o_wk; ge = o_er; gd = o_rd;
      end else if (hmid && stalls == 2) begin
        halt = 1'b1;
      end
    end
    check("response_seen", 32'(done), 32'd1);
  endtask

  task automatic run(input bit r, input logic [3:0] s,
                     input logic [2:0] f, input logic [31:0] a,
                     input logic [31:0] w, output logic [31:0] gd);
    int st;
    bit gr, gw, ge, eerr;
    logic [31:0] ed;
    xact(r, s, f, a, w, 1'b0, st, gr, gw, ge, gd);
    model(r, s, f, a, w, eerr, ed);
    check("stall_len", 32'(st), 32'd2);
    check("rvalid", 32'(gr), 32'(r));
    check("wack", 32'(gw), 32'(!r));
    check("mem_err", 32'(ge), 32'(eerr));
    if (r) begin
      check("rdata", gd, ed);
      last = ed;
    end else begin
      check("rdata_hold", gd, last);
    end
  endtask

  initial begin
    logic [31:0] gd, word, a;
    logic [3:0] legal_s [7];
    logic [2:0] legal_f [5];
    logic [3:0] s;
    logic [2:0] f;
    bit r, gr, gw, ge;
    int st, k, p;
    int lat [3];
    legal_s = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd3, 4'd12, 4'd15};
    legal_f = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    lat = '{2, 1, 15};

    rst = 1'b1; re = 0; we = 0; f3 = 0; ad = 0; wd = 0;
    halt = 0; sel = 0; last = 32'd0;
    @(negedge clk);
    check("rst_stall", 32'(o_st), 32'd0);
    check("rst_rvalid", 32'(o_rv), 32'd0);
    check("rst_wack", 32'(o_wk), 32'd0);
    check("rst_err", 32'(o_er), 32'd0);
    check("rst_rdata", o_rd, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 16; i++)
      run(0, 4'hF, 3'd2, 32'(i * 4), $urandom, gd);
    run(0, 4'hF, 3'd2, 32'((DEPTH - 1) * 4), $urandom, gd);

    run(0, 4'hF, 3'd2, 32'h10, 32'hDEADBEEF, gd);
    run(1, 4'h0, 3'd2, 32'h10, 32'd0, gd);
    check("s1_lw", gd, 32'hDEADBEEF);

    run(0, 4'b0010, 3'd0, 32'h11, 32'h0000_7F00, gd);
    run(1, 4'h0, 3'd0, 32'h11, 32'd0, gd);
    check("s2_lb11", gd, 32'h0000007F);
    run(1, 4'h0, 3'd4, 32'h13, 32'd0, gd);
    check("s2_lbu13", gd, 32'h000000DE);
    run(1, 4'h0, 3'd0, 32'h13, 32'd0, gd);
    check("s2_lb13", gd, 32'hFFFFFFDE);

    run(1, 4'h0, 3'd1, 32'h13, 32'd0, gd);
    check("s3_lh_mis", gd, 32'd0);
    run(0, 4'b0110, 3'd0, 32'h10, 32'hFFFFFFFF, gd);
    run(1, 4'h0, 3'd2, 32'h10, 32'd0, gd);
    check("s3_untouched", gd, 32'hDEAD7FEF);

    run(1, 4'h0, 3'd2, 32'(DEPTH * 4), 32'd0, gd);
    check("s4_oor", gd, 32'd0);
    run(1, 4'h0, 3'd2, 32'((DEPTH - 1) * 4), 32'd0, gd);

    @(posedge clk);
    #1;
    halt = 1; re = 1; we = 0; f3 = 3'd2; ad = 32'h10;
    repeat (4) begin
      @(negedge clk);
      check("halt_idle_stall", 32'(o_st), 32'd0);
      check("halt_idle_rvalid", 32'(o_rv), 32'd0);
    end
    @(posedge clk);
    #1 re = 0;
    @(posedge clk);
    #1 halt = 0;

    xact(1, 4'h0, 3'd2, 32'h10, 32'd0, 1'b1, st, gr, gw, ge, gd);
    check("hmid_stall", 32'(st), 32'd2);
    check("hmid_rvalid", 32'(gr), 32'd1);
    check("hmid_err", 32'(ge), 32'd0);
    check("hmid_rdata", gd, 32'hDEAD7FEF);
    last = gd;
    @(negedge clk);
    check("hmid_noaccept", 32'(o_st), 32'd0);
    check("hmid_norvalid", 32'(o_rv), 32'd0);
    @(posedge clk);
    #1;
    re = 0; halt = 0;

    @(posedge clk);
    #1;
    we = 4'hF; ad = 32'h10; wd = 32'h12345678; f3 = 3'd2;
    @(negedge clk);
    check("s6_accept_stall", 32'(o_st), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("s6_stall", 32'(o_st), 32'd0);
    check("s6_wack", 32'(o_wk), 32'd0);
    check("s6_rvalid", 32'(o_rv), 32'd0);
    check("s6_err", 32'(o_er), 32'd0);
    check("s6_rdata", o_rd, 32'd0);
    last = 32'd0;
    @(posedge clk);
    #1;
    we = 0; rst = 1'b0;
    run(1, 4'h0, 3'd2, 32'h10, 32'd0, gd);
    check("s6_old_data", gd, 32'hDEAD7FEF);

    for (int i = 0; i < 150; i++) begin
      k = $urandom % 10;
      r = (k < 4) || (k == 9);
      p = $urandom % 10;
      if (p < 8) word = $urandom % 16;
      else if (p == 8) word = DEPTH - 1;
      else word = $urandom_range(32'h3FFF_FFFF, DEPTH);
      a = {word[29:0], 2'(($urandom % 4))};
      if (($urandom % 10) < 7) s = legal_s[$urandom % 7];
      else s = 4'(1 + $urandom % 15);
      if (r && k < 4) s = 4'd0;
      if (($urandom % 10) < 8) f = legal_f[$urandom % 5];
      else f = 3'($urandom % 8);
      run(r, s, f, a, $urandom, gd);
    end

    for (int j = 1; j < 3; j++) begin
      @(posedge clk);
      #1;
      re = 0; we = 0; sel = j;
      xact(0, 4'hF, 3'd2, 32'h10, 32'hDEADBEEF, 1'b0,
           st, gr, gw, ge, gd);
      check("lat_sw_stall", 32'(st), 32'(lat[j]));
      check("lat_sw_wack", 32'(gw), 32'd1);
      xact(1, 4'h0, 3'd2, 32'h10, 32'd0, 1'b0, st, gr, gw, ge, gd);
      check("lat_lw_stall", 32'(st), 32'(lat[j]));
      check("lat_lw_rvalid", 32'(gr), 32'd1);
      check("lat_lw_rdata", gd, 32'hDEADBEEF);
    end
    @(posedge clk);
    #1;
    re = 0; we = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
